// File: rtl/i2c_eeprom_responder.sv
// I2C slave emulating a small 24Cxx-style EEPROM page, preloadable from fabric.
// Optional write protect input enabled by defining I2C_RESP_WP_EN.
module i2c_eeprom_responder #(
   parameter int PAGE_BYTES = 8,
   parameter int FILT_LEN   = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] i_dev_addr,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda,
   output logic       t_sda,
   input  logic       i_ld_en,
   input  logic [7:0] i_ld_addr,
   input  logic [7:0] i_ld_data,
`ifdef I2C_RESP_WP_EN
   input  logic       i_wp,
`endif
   output logic [7:0] o_page_b0,
   output logic [7:0] o_page_b1,
   output logic [7:0] o_page_b2,
   output logic [7:0] o_page_b3,
   output logic [7:0] o_page_b4,
   output logic [7:0] o_page_b5,
   output logic [7:0] o_page_b6,
   output logic [7:0] o_page_b7,
   output logic       o_busy,
   output logic       o_wr_pulse,
   output logic       o_stop_pulse
);

   localparam int AW = $clog2(PAGE_BYTES);
   localparam int FW = $clog2(FILT_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEV,
      S_ACK_DEV,
      S_WADDR,
      S_ACK_WADDR,
      S_WDATA,
      S_ACK_WDATA,
      S_RDATA,
      S_MACK,
      S_IGNORE
   } state_t;

   logic          wp;
`ifdef I2C_RESP_WP_EN
   assign wp = i_wp;
`else
   assign wp = 1'b0;
`endif

   // index 0 = SCL, index 1 = SDA
   logic [1:0]    s1, s2, filt, filt_d;
   logic [FW-1:0] fcnt [2];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1     <= 2'b11;
         s2     <= 2'b11;
         filt   <= 2'b11;
         filt_d <= 2'b11;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         s1     <= {i_sda, i_scl};
         s2     <= s1;
         filt_d <= filt;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
               filt[i] <= s2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_p, sda_p;
   logic start_ev, stop_ev, rise, fall;

   assign scl_f    = filt[0];
   assign sda_f    = filt[1];
   assign scl_p    = filt_d[0];
   assign sda_p    = filt_d[1];
   assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;
   assign rise     = scl_f & ~scl_p;
   assign fall     = ~scl_f & scl_p;

   state_t        state;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    tx;
   logic          rw;
   logic          nack;
   logic          mack_bit;
   logic          fall_d;
   logic          t_sda_r;
   logic          busy;
   logic          wr_pulse;
   logic          stop_pulse;
   logic [AW-1:0] addr;
   logic [7:0]    page [PAGE_BYTES];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx         <= '0;
         rw         <= 1'b0;
         nack       <= 1'b0;
         mack_bit   <= 1'b1;
         fall_d     <= 1'b0;
         t_sda_r    <= 1'b1;
         busy       <= 1'b0;
         wr_pulse   <= 1'b0;
         stop_pulse <= 1'b0;
         addr       <= '0;
         for (int i = 0; i < PAGE_BYTES; i++) page[i] <= '0;
      end else begin
         wr_pulse   <= 1'b0;
         stop_pulse <= 1'b0;
         fall_d     <= fall;
         if (i_ld_en) page[i_ld_addr[AW-1:0]] <= i_ld_data;
         if (start_ev) begin
            state   <= S_DEV;
            bit_cnt <= '0;
            t_sda_r <= 1'b1;
         end else if (stop_ev) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            t_sda_r    <= 1'b1;
            busy       <= 1'b0;
            stop_pulse <= busy;
         end else begin
            if (rise) begin
               case (state)
                  S_DEV, S_WADDR, S_WDATA: begin
                     shreg   <= {shreg[6:0], sda_f};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  S_RDATA: bit_cnt <= bit_cnt + 1'b1;
                  S_MACK: begin
                     mack_bit <= sda_f;
                     addr     <= addr + 1'b1;
                  end
                  default: ;
               endcase
            end
            if (fall) begin
               case (state)
                  S_DEV: if (bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     if (shreg[7:1] == i_dev_addr) begin
                        state <= S_ACK_DEV;
                        busy  <= 1'b1;
                        rw    <= shreg[0];
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
                  S_ACK_DEV: if (rw) begin
                     state <= S_RDATA;
                     tx    <= page[addr];
                  end else begin
                     state <= S_WADDR;
                  end
                  S_WADDR: if (bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     addr    <= shreg[AW-1:0];
                     state   <= S_ACK_WADDR;
                  end
                  S_ACK_WADDR: state <= S_WDATA;
                  S_WDATA: if (bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     state   <= S_ACK_WDATA;
                     nack    <= wp;
                     addr    <= addr + 1'b1;
                     if (!wp) begin
                        page[addr] <= shreg;
                        wr_pulse   <= 1'b1;
                     end
                  end
                  S_ACK_WDATA: state <= S_WDATA;
                  S_RDATA: if (bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     state   <= S_MACK;
                  end else begin
                     tx <= {tx[6:0], 1'b0};
                  end
                  S_MACK: if (!mack_bit) begin
                     state <= S_RDATA;
                     tx    <= page[addr];
                  end else begin
                     state <= S_IGNORE;
                  end
                  default: ;
               endcase
            end
            // SDA only moves one cycle after SCL has settled low
            if (fall_d) begin
               case (state)
                  S_ACK_DEV, S_ACK_WADDR: t_sda_r <= 1'b0;
                  S_ACK_WDATA:            t_sda_r <= nack;
                  S_RDATA:                t_sda_r <= tx[7];
                  default:                t_sda_r <= 1'b1;
               endcase
            end
         end
      end
   end

   logic [7:0] view [8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         view[i] = '0;
         if (i < PAGE_BYTES) view[i] = page[AW'(i)];
      end
   end

   logic unused_ld_bits;
   assign unused_ld_bits = ^i_ld_addr;

   assign o_sda        = 1'b0;
   assign t_sda        = t_sda_r;
   assign o_busy       = busy;
   assign o_wr_pulse   = wr_pulse;
   assign o_stop_pulse = stop_pulse;
   assign o_page_b0    = view[0];
   assign o_page_b1    = view[1];
   assign o_page_b2    = view[2];
   assign o_page_b3    = view[3];
   assign o_page_b4    = view[4];
   assign o_page_b5    = view[5];
   assign o_page_b6    = view[6];
   assign o_page_b7    = view[7];

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Directed bench for i2c_eeprom_responder: bit-banged I2C master on a
// wired-AND SDA line with hand-computed expected values.
module tb_i2c_eeprom_responder;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] dev_addr = 7'h50;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       o_sda, t_sda;
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
`ifdef I2C_RESP_WP_EN
   logic       wp = 1'b0;
`endif
   logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;
   logic       busy, wr_pulse, stop_pulse;

   assign sda_line = sda_m & (t_sda | o_sda);

   always #25 clk = ~clk;

   i2c_eeprom_responder dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_dev_addr   (dev_addr),
      .i_scl        (scl_m),
      .i_sda        (sda_line),
      .o_sda        (o_sda),
      .t_sda        (t_sda),
      .i_ld_en      (ld_en),
      .i_ld_addr    (ld_addr),
      .i_ld_data    (ld_data),
`ifdef I2C_RESP_WP_EN
      .i_wp         (wp),
`endif
      .o_page_b0    (b0),
      .o_page_b1    (b1),
      .o_page_b2    (b2),
      .o_page_b3    (b3),
      .o_page_b4    (b4),
      .o_page_b5    (b5),
      .o_page_b6    (b6),
      .o_page_b7    (b7),
      .o_busy       (busy),
      .o_wr_pulse   (wr_pulse),
      .o_stop_pulse (stop_pulse)
   );

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int stop_cnt = 0;
   int drv_cnt = 0;
   int busy_cnt = 0;

   always @(negedge clk) begin
      if (wr_pulse) wr_cnt++;
      if (stop_pulse) stop_cnt++;
      if (!t_sda) drv_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic wbit(input logic b);
      sda_m = b;    wq(Q);
      scl_m = 1'b1; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic rbit(output logic b);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q / 2);
      b = sda_line; wq(Q / 2);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(ack);
   endtask

   task automatic rbyte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(ack);
   endtask

   logic [7:0] d;
   logic       ack;
   int         s0, w0, v0, u0;
   logic [7:0] seq_exp [10];

   initial begin
      seq_exp = '{8'h17, 8'h18, 8'h11, 8'h12, 8'h13,
                  8'h14, 8'h15, 8'h16, 8'h17, 8'h18};

      wq(4);
      chk("rst_t_sda", t_sda, 1);
      chk("rst_o_sda", o_sda, 0);
      chk("rst_busy", busy, 0);
      chk("rst_b0", b0, 8'h00);
      chk("rst_pulses", {wr_pulse, stop_pulse}, 0);
      reset_n = 1'b1;
      wq(2);

      for (int i = 0; i < 8; i++) begin
         ld_en = 1'b1;
         ld_addr = 8'(i);
         ld_data = 8'h11 + 8'(i);
         wq(1);
      end
      ld_en = 1'b0;
      wq(1);
      chk("pre_b0", b0, 8'h11);
      chk("pre_b7", b7, 8'h18);

      // random read of one byte at address 0
      s0 = stop_cnt;
      i2c_start();
      wbyte(8'hA0, ack); chk("rr_ack_dev", ack, 0);
      chk("rr_busy", busy, 1);
      wbyte(8'h00, ack); chk("rr_ack_wa", ack, 0);
      i2c_start();
      wbyte(8'hA1, ack); chk("rr_ack_rd", ack, 0);
      rbyte(d, 1'b1);    chk("rr_data", d, 8'h11);
      i2c_stop();
      wq(Q);
      chk("rr_stop_pulse", stop_cnt - s0, 1);
      chk("rr_busy_end", busy, 0);

      // sequential read of 10 bytes from address 6
      i2c_start();
      wbyte(8'hA0, ack); chk("sr_ack_dev", ack, 0);
      wbyte(8'h06, ack); chk("sr_ack_wa", ack, 0);
      i2c_start();
      wbyte(8'hA1, ack); chk("sr_ack_rd", ack, 0);
      for (int k = 0; k < 10; k++) begin
         rbyte(d, (k == 9));
         chk($sformatf("sr_byte%0d", k), d, seq_exp[k]);
      end
      i2c_stop();
      wq(Q);

      // write two bytes at address 3
      w0 = wr_cnt;
      i2c_start();
      wbyte(8'hA0, ack); chk("w3_ack_dev", ack, 0);
      wbyte(8'h03, ack); chk("w3_ack_wa", ack, 0);
      wbyte(8'hA5, ack); chk("w3_ack_d0", ack, 0);
      wbyte(8'h5A, ack); chk("w3_ack_d1", ack, 0);
      i2c_stop();
      wq(Q);
      chk("w3_b3", b3, 8'hA5);
      chk("w3_b4", b4, 8'h5A);
      chk("w3_wr_pulses", wr_cnt - w0, 2);

      // write wrapping from address 7 to 0
      i2c_start();
      wbyte(8'hA0, ack);
      wbyte(8'h07, ack);
      wbyte(8'hC3, ack); chk("w7_ack_d0", ack, 0);
      wbyte(8'h3C, ack); chk("w7_ack_d1", ack, 0);
      i2c_stop();
      wq(Q);
      chk("w7_b7", b7, 8'hC3);
      chk("w7_b0", b0, 8'h3C);

      // foreign device address 0x51
      v0 = drv_cnt; u0 = busy_cnt; s0 = stop_cnt;
      i2c_start();
      wbyte(8'hA2, ack); chk("na_nack", ack, 1);
      wbyte(8'h00, ack);
      i2c_stop();
      wq(Q);
      chk("na_never_drive", drv_cnt - v0, 0);
      chk("na_never_busy", busy_cnt - u0, 0);
      chk("na_no_stop_pulse", stop_cnt - s0, 0);

      // repeated START part way through a data byte
      w0 = wr_cnt;
      i2c_start();
      wbyte(8'hA0, ack);
      wbyte(8'h02, ack); chk("rs_ack_wa", ack, 0);
      for (int i = 0; i < 4; i++) wbit(1'b1);
      i2c_start();
      wbyte(8'hA1, ack); chk("rs_ack_rd", ack, 0);
      rbyte(d, 1'b1);    chk("rs_data", d, 8'h13);
      i2c_stop();
      wq(Q);
      chk("rs_b2_kept", b2, 8'h13);
      chk("rs_no_store", wr_cnt - w0, 0);

      // one-cycle SCL glitch must not shift a bit
      w0 = wr_cnt;
      i2c_start();
      wbyte(8'hA0, ack);
      scl_m = 1'b1; wq(1);
      scl_m = 1'b0; wq(Q);
      wbyte(8'h05, ack); chk("gl_ack_wa", ack, 0);
      wbyte(8'h77, ack); chk("gl_ack_d", ack, 0);
      i2c_stop();
      wq(Q);
      chk("gl_b5", b5, 8'h77);
      chk("gl_b6", b6, 8'h17);
      chk("gl_wr_pulse", wr_cnt - w0, 1);

      // reset while driving a 0 data bit (page[0] = 0x3C)
      i2c_start();
      wbyte(8'hA0, ack);
      wbyte(8'h00, ack);
      i2c_start();
      wbyte(8'hA1, ack);
      chk("rd_drive_msb", t_sda, 0);
      reset_n = 1'b0;
      wq(1);
      chk("rd_rst_release", t_sda, 1);
      chk("rd_rst_b0", b0, 8'h00);
      chk("rd_rst_b3", b3, 8'h00);
      reset_n = 1'b1;
      sda_m = 1'b1;
      scl_m = 1'b1;
      wq(Q);

`ifdef I2C_RESP_WP_EN
      w0 = wr_cnt;
      wp = 1'b1;
      i2c_start();
      wbyte(8'hA0, ack); chk("wp_ack_dev", ack, 0);
      wbyte(8'h02, ack); chk("wp_ack_wa", ack, 0);
      wbyte(8'hFF, ack); chk("wp_nack_d", ack, 1);
      i2c_stop();
      wq(Q);
      chk("wp_b2", b2, 8'h00);
      chk("wp_no_pulse", wr_cnt - w0, 0);
      wp = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
